// File: rtl/bsg_ready_to_credit_vc_arbiter.sv
// Round-robin credit arbiter: els_p valid/ready channels onto one credited link.
// Optional sticky overflow flags and check: define BSG_READY_TO_CREDIT_VC_OVERFLOW_ERR_EN.
module bsg_ready_to_credit_vc_arbiter #(
    parameter int els_p            = 2,
    parameter int width_p          = 32,
    parameter int credit_max_val_p = 8,
    parameter int decimation_p     = 1
) (
    input  logic                                      clk_i,
    input  logic                                      reset_n_i,
    input  logic [els_p-1:0]                          v_i,
    input  logic [els_p*width_p-1:0]                  data_i,
    output logic [els_p-1:0]                          ready_o,
    output logic                                      v_o,
    output logic [width_p-1:0]                        data_o,
    output logic [((els_p > 1) ? $clog2(els_p) : 1)-1:0] vc_id_o,
    input  logic [els_p-1:0]                          credit_i,
    output logic [els_p-1:0]                          credit_avail_o
`ifdef BSG_READY_TO_CREDIT_VC_OVERFLOW_ERR_EN
    ,
    output logic [els_p-1:0]                          overflow_o
`endif
);

    localparam int cw = $clog2(credit_max_val_p + 1);
    localparam int pw = (els_p > 1) ? $clog2(els_p) : 1;
    localparam int unsigned els_lp = els_p;

    logic [cw-1:0]    cnt      [els_p];
    logic [cw-1:0]    cnt_next [els_p];
    logic [cw:0]      sum      [els_p];
    logic [els_p-1:0] sat;
    logic [els_p-1:0] eligible;
    logic [pw-1:0]    ptr;
    logic [pw-1:0]    ptr_next;
    logic [pw-1:0]    gnt;
    logic             found;
    int unsigned      idx;

    always_comb begin
        for (int unsigned i = 0; i < els_lp; i++) begin
            eligible[i]       = v_i[i] && (cnt[i] != '0);
            credit_avail_o[i] = (cnt[i] != '0);
        end
    end

    // Scan from the pointer upward with wraparound; the first eligible channel wins.
    always_comb begin
        found = 1'b0;
        gnt   = '0;
        idx   = 0;
        for (int unsigned k = 0; k < els_lp; k++) begin
            idx = (32'(ptr) + k) % els_lp;
            if (!found && eligible[idx]) begin
                found = 1'b1;
                gnt   = pw'(idx);
            end
        end
    end

    always_comb begin
        ready_o = '0;
        data_o  = '0;
        v_o     = found;
        vc_id_o = found ? gnt : '0;
        for (int unsigned i = 0; i < els_lp; i++) begin
            if (found && (gnt == pw'(i))) begin
                ready_o[i] = 1'b1;
                data_o     = data_i[i*width_p +: width_p];
            end
        end
    end

    always_comb begin
        if ((els_p == 1) || (gnt == pw'(els_p - 1)))
            ptr_next = '0;
        else
            ptr_next = gnt + pw'(1);
    end

    // One extra bit holds cnt + decimation_p (at most 2*max) before clamping.
    always_comb begin
        for (int unsigned i = 0; i < els_lp; i++) begin
            sum[i] = {1'b0, cnt[i]}
                   + (credit_i[i] ? (cw+1)'(decimation_p) : '0)
                   - ((found && (gnt == pw'(i))) ? (cw+1)'(1) : '0);
            sat[i] = (sum[i] > (cw+1)'(credit_max_val_p));
            cnt_next[i] = sat[i] ? cw'(credit_max_val_p) : sum[i][cw-1:0];
        end
    end

    always_ff @(posedge clk_i) begin
        if (!reset_n_i) begin
            for (int unsigned i = 0; i < els_lp; i++)
                cnt[i] <= cw'(credit_max_val_p);
            ptr <= '0;
        end else begin
            for (int unsigned i = 0; i < els_lp; i++)
                cnt[i] <= cnt_next[i];
            if (found)
                ptr <= ptr_next;
        end
    end

`ifdef BSG_READY_TO_CREDIT_VC_OVERFLOW_ERR_EN
    logic [els_p-1:0] overflow_r;

    always_ff @(posedge clk_i) begin
        if (!reset_n_i)
            overflow_r <= '0;
        else
            overflow_r <= overflow_r | sat;
    end

    assign overflow_o = overflow_r;

`ifndef SYNTHESIS
    always_ff @(posedge clk_i) begin
        if (reset_n_i && (|sat)) begin
            $error("bsg_ready_to_credit_vc_arbiter: credit overflow on channels %b", sat);
            $stop;
        end
    end
`endif
`endif

endmodule

// File: tb/tb_bsg_ready_to_credit_vc_arbiter.sv
// Drives three arbiters (decimation 1, 2, 4) with shared stimulus and checks each against a credit model.
module tb_bsg_ready_to_credit_vc_arbiter;

    localparam int ND = 3;
    localparam int W  = 32;
    localparam int MX = 8;

    logic          clk = 1'b0;
    logic          reset_n;
    logic [1:0]    v_i;
    logic [2*W-1:0] data_i;
    logic [1:0]    credit_i;

    logic [1:0]    ready_w [ND];
    logic          v_w     [ND];
    logic [W-1:0]  data_w  [ND];
    logic [0:0]    vc_w    [ND];
    logic [1:0]    avail_w [ND];
`ifdef BSG_READY_TO_CREDIT_VC_OVERFLOW_ERR_EN
    logic [1:0]    ovf_w   [ND];
`endif

    int tests = 0;
    int fails = 0;

    int mcnt [ND][2];
    int mptr [ND];
    int mdec [ND];
    int mgnt [ND];
    bit mvalid = 0;

    always #5 clk = ~clk;

    for (genvar d = 0; d < ND; d++) begin : g_dut
        bsg_ready_to_credit_vc_arbiter #(
            .els_p(2), .width_p(W), .credit_max_val_p(MX), .decimation_p(1 << d)
        ) dut (
            .clk_i(clk), .reset_n_i(reset_n), .v_i(v_i), .data_i(data_i),
            .ready_o(ready_w[d]), .v_o(v_w[d]), .data_o(data_w[d]), .vc_id_o(vc_w[d]),
            .credit_i(credit_i), .credit_avail_o(avail_w[d])
`ifdef BSG_READY_TO_CREDIT_VC_OVERFLOW_ERR_EN
            , .overflow_o(ovf_w[d])
`endif
        );
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step(input logic rn, input logic [1:0] v, input logic [1:0] cr);
        reset_n  = rn;
        v_i      = v;
        credit_i = cr;
        data_i   = {$urandom(), $urandom()};
        #1;
        for (int d = 0; d < ND; d++) begin
            logic [1:0] er, ea;
            logic [W-1:0] ed;
            mgnt[d] = -1;
            for (int k = 0; k < 2; k++) begin
                int c;
                c = (mptr[d] + k) % 2;
                if (mgnt[d] < 0 && v[c] && mcnt[d][c] > 0) mgnt[d] = c;
            end
            if (mvalid) begin
                er = '0; ed = '0; ea = '0;
                if (mgnt[d] >= 0) begin
                    er[mgnt[d]] = 1'b1;
                    ed = data_i[mgnt[d]*W +: W];
                end
                for (int c = 0; c < 2; c++) ea[c] = (mcnt[d][c] != 0);
                check($sformatf("ready[d%0d]", d), 64'(ready_w[d]), 64'(er));
                check($sformatf("v_o[d%0d]", d), 64'(v_w[d]), 64'(mgnt[d] >= 0));
                check($sformatf("data[d%0d]", d), 64'(data_w[d]), 64'(ed));
                check($sformatf("vc_id[d%0d]", d), 64'(vc_w[d]), (mgnt[d] >= 0) ? 64'(mgnt[d]) : 64'd0);
                check($sformatf("avail[d%0d]", d), 64'(avail_w[d]), 64'(ea));
            end
        end
        @(posedge clk);
        for (int d = 0; d < ND; d++) begin
            if (!rn) begin
                mcnt[d][0] = MX; mcnt[d][1] = MX; mptr[d] = 0;
            end else begin
                for (int c = 0; c < 2; c++) begin
                    int n;
                    n = mcnt[d][c] + (cr[c] ? mdec[d] : 0) - ((mgnt[d] == c) ? 1 : 0);
                    mcnt[d][c] = (n > MX) ? MX : n;
                end
                if (mgnt[d] >= 0) mptr[d] = (mgnt[d] + 1) % 2;
            end
        end
        if (!rn) mvalid = 1;
        @(negedge clk);
    endtask

    initial begin
        for (int d = 0; d < ND; d++) mdec[d] = 1 << d;
        reset_n = 1'b0; v_i = '0; credit_i = '0; data_i = '0;
        @(negedge clk);

        // reset, then both channels valid until credits run out
        step(0, 2'b00, 2'b00);
        step(0, 2'b00, 2'b00);
        check("reset_avail", 64'(avail_w[0]), 64'h3);
        for (int i = 0; i < 18; i++) step(1, 2'b11, 2'b00);
        check("drained_v_o", 64'(v_w[0]), 64'h0);

        // ch1 alone drains, a returned credit becomes usable a cycle later
        step(0, 2'b00, 2'b00);
        for (int i = 0; i < 8; i++) step(1, 2'b10, 2'b00);
        step(1, 2'b10, 2'b10);
        step(1, 2'b10, 2'b00);
        step(1, 2'b10, 2'b00);

        // cnt0=3 then same-cycle send + return, then drain
        step(0, 2'b00, 2'b00);
        for (int i = 0; i < 5; i++) step(1, 2'b01, 2'b00);
        step(1, 2'b01, 2'b01);
        for (int i = 0; i < 9; i++) step(1, 2'b01, 2'b00);

        // cnt0=7 with a return: saturation
        step(0, 2'b00, 2'b00);
        step(1, 2'b01, 2'b00);
        step(1, 2'b00, 2'b01);
        for (int i = 0; i < 10; i++) step(1, 2'b01, 2'b00);

        // ch0 empty, ch1 keeps flowing
        step(0, 2'b00, 2'b00);
        for (int i = 0; i < 8; i++) step(1, 2'b01, 2'b00);
        for (int i = 0; i < 5; i++) step(1, 2'b11, 2'b00);

        // reset mid-stream with counts {2,5}
        step(0, 2'b00, 2'b00);
        for (int i = 0; i < 6; i++) step(1, 2'b01, 2'b00);
        for (int i = 0; i < 3; i++) step(1, 2'b10, 2'b00);
        step(0, 2'b11, 2'b00);
        step(1, 2'b11, 2'b00);
        check("post_reset_vc", 64'(vc_w[0]), 64'h1);

        // randomized traffic with occasional resets
        for (int i = 0; i < 500; i++) begin
            logic rn;
            logic [1:0] cr;
            rn = ($urandom_range(0, 99) != 0);
            cr = {($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0)};
            step(rn, 2'($urandom()), cr);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
